// File: rtl/debug_dump_tx.sv
// debug_dump_tx
//   After the pipeline halts, serialises execution state to the host through
//   tx_uart: the PC (zero-extended to NB_DATA), then reg[0..N_REGS-1], then
//   data-memory words [0..N_MEM_WORDS-1]. Each word goes out as 4 bytes, MSB
//   first. The register bank and DATAmem are read through borrowed ports that
//   the top level grants while busy_o=1 (one-cycle read latency assumed).
//
//   Optional feature (macro DEBUG_DUMP_CHECKSUM_EN): an 8-bit XOR of every
//   byte sent is appended as one extra byte after the last memory byte.
//
// Ports
//   clock          in   system clock, rising edge
//   reset          in   synchronous, active-high
//   start_i        in   one-cycle dump request (honoured only in IDLE)
//   pc_i           in   halted PC
//   reg_addr_o     out  register bank read address
//   reg_data_i     in   register bank read data
//   mem_addr_o     out  DATAmem byte address (word aligned)
//   mem_data_i     in   DATAmem read data
//   tx_done_tick_i in   tx_uart finished the current byte
//   tx_start_o     out  one-cycle pulse, start sending tx_data_o
//   tx_data_o      out  byte to send
//   busy_o         out  dump in progress
//   done_o         out  one-cycle pulse after the last byte is acknowledged
module debug_dump_tx #(
  parameter int NB_DATA     = 32,
  parameter int NB_REG      = 5,
  parameter int N_REGS      = 32,
  parameter int NB_MEM_ADDR = 7,
  parameter int N_MEM_WORDS = 32,
  parameter int NB_PC       = 7,
  parameter int N_BITS      = 8
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   start_i,
  input  logic [NB_PC-1:0]       pc_i,
  output logic [NB_REG-1:0]      reg_addr_o,
  input  logic [NB_DATA-1:0]     reg_data_i,
  output logic [NB_MEM_ADDR-1:0] mem_addr_o,
  input  logic [NB_DATA-1:0]     mem_data_i,
  input  logic                   tx_done_tick_i,
  output logic                   tx_start_o,
  output logic [N_BITS-1:0]      tx_data_o,
  output logic                   busy_o,
  output logic                   done_o
);

  localparam int N_WORDS_MAX = (N_REGS > N_MEM_WORDS) ? N_REGS : N_MEM_WORDS;
  // One spare count so the index never wraps inside a frame.
  localparam int NB_WIDX = $clog2(N_WORDS_MAX + 1);
  localparam logic [NB_WIDX-1:0] LAST_REG = NB_WIDX'(N_REGS - 1);
  localparam logic [NB_WIDX-1:0] LAST_MEM = NB_WIDX'(N_MEM_WORDS - 1);

  typedef enum logic [3:0] {
    S_IDLE,
    S_LOAD_PC,
    S_SEND,
    S_WAIT_TX,
    S_FETCH_ADDR,
    S_FETCH_LATCH,
`ifdef DEBUG_DUMP_CHECKSUM_EN
    S_SEND_CSUM,
    S_WAIT_CSUM,
`endif
    S_FINISH
  } state_t;

  typedef enum logic [1:0] {SRC_PC, SRC_REG, SRC_MEM} src_t;

  state_t                   r_state;
  state_t                   w_next;
  src_t                     r_src;
  logic [NB_DATA-1:0]       r_shift;
  logic [1:0]               r_byte_cnt;
  logic [NB_WIDX-1:0]       r_word_idx;
  logic [NB_REG-1:0]        r_reg_addr;
  logic [NB_MEM_ADDR-1:0]   r_mem_addr;
  logic [N_BITS-1:0]        r_tx_data;
  logic                     w_tx_start;
  logic                     w_busy;
  logic                     w_done;
  logic [NB_WIDX-1:0]       w_idx_inc;
  logic                     w_frame_end;
`ifdef DEBUG_DUMP_CHECKSUM_EN
  logic [N_BITS-1:0]        r_csum;
`endif

  assign w_idx_inc   = r_word_idx + 1'b1;
  assign w_frame_end = (r_src == SRC_MEM) && (r_word_idx == LAST_MEM);

  // Next state and control outputs
  always_comb begin
    w_next     = r_state;
    w_tx_start = 1'b0;
    w_busy     = 1'b1;
    w_done     = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_busy = 1'b0;
        if (start_i) w_next = S_LOAD_PC;
      end
      S_LOAD_PC:     w_next = S_SEND;
      S_SEND: begin
        w_tx_start = 1'b1;
        w_next     = S_WAIT_TX;
      end
      S_WAIT_TX: begin
        if (tx_done_tick_i) begin
          if (r_byte_cnt != 2'd3) begin
            w_next = S_SEND;
          end else if (w_frame_end) begin
`ifdef DEBUG_DUMP_CHECKSUM_EN
            w_next = S_SEND_CSUM;
`else
            w_next = S_FINISH;
`endif
          end else begin
            w_next = S_FETCH_ADDR;
          end
        end
      end
      S_FETCH_ADDR:  w_next = S_FETCH_LATCH;
      S_FETCH_LATCH: w_next = S_SEND;
`ifdef DEBUG_DUMP_CHECKSUM_EN
      S_SEND_CSUM: begin
        w_tx_start = 1'b1;
        w_next     = S_WAIT_CSUM;
      end
      S_WAIT_CSUM: if (tx_done_tick_i) w_next = S_FINISH;
`endif
      S_FINISH: begin
        w_busy = 1'b0;
        w_done = 1'b1;
        w_next = S_IDLE;
      end
      default: begin
        w_busy = 1'b0;
        w_next = S_IDLE;
      end
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_src      <= SRC_PC;
      r_shift    <= '0;
      r_byte_cnt <= '0;
      r_word_idx <= '0;
      r_reg_addr <= '0;
      r_mem_addr <= '0;
      r_tx_data  <= '0;
`ifdef DEBUG_DUMP_CHECKSUM_EN
      r_csum     <= '0;
`endif
    end else begin
      r_state <= w_next;
      case (r_state)
        S_LOAD_PC: begin
          r_shift    <= {{(NB_DATA-NB_PC){1'b0}}, pc_i};
          r_byte_cnt <= '0;
          r_word_idx <= '0;
          r_src      <= SRC_PC;
`ifdef DEBUG_DUMP_CHECKSUM_EN
          r_csum     <= '0;
`endif
        end
        S_SEND: begin
          r_tx_data <= r_shift[NB_DATA-1 -: N_BITS];
`ifdef DEBUG_DUMP_CHECKSUM_EN
          r_csum    <= r_csum ^ r_shift[NB_DATA-1 -: N_BITS];
`endif
        end
        S_WAIT_TX: begin
          if (tx_done_tick_i) begin
            r_shift    <= r_shift << N_BITS;
            r_byte_cnt <= r_byte_cnt + 2'd1;
            // Word boundary: the address is set here so it is already stable
            // during FETCH_ADDR, when the synchronous read samples it.
            if (r_byte_cnt == 2'd3) begin
              case (r_src)
                SRC_PC: begin
                  r_src      <= SRC_REG;
                  r_word_idx <= '0;
                  r_reg_addr <= '0;
                end
                SRC_REG: begin
                  if (r_word_idx == LAST_REG) begin
                    r_src      <= SRC_MEM;
                    r_word_idx <= '0;
                    r_mem_addr <= '0;
                  end else begin
                    r_word_idx <= w_idx_inc;
                    r_reg_addr <= NB_REG'(w_idx_inc);
                  end
                end
                default: begin
                  if (!w_frame_end) begin
                    r_word_idx <= w_idx_inc;
                    r_mem_addr <= {(NB_MEM_ADDR-2)'(w_idx_inc), 2'b00};
                  end
                end
              endcase
            end
          end
        end
        S_FETCH_LATCH: r_shift <= (r_src == SRC_MEM) ? mem_data_i : reg_data_i;
`ifdef DEBUG_DUMP_CHECKSUM_EN
        S_SEND_CSUM:   r_tx_data <= r_csum;
`endif
        default: ;
      endcase
    end
  end

  // The byte is presented combinationally during the start pulse and held
  // from r_tx_data until the next SEND.
  always_comb begin
    tx_data_o = r_tx_data;
    if (r_state == S_SEND) tx_data_o = r_shift[NB_DATA-1 -: N_BITS];
`ifdef DEBUG_DUMP_CHECKSUM_EN
    if (r_state == S_SEND_CSUM) tx_data_o = r_csum;
`endif
  end

  assign tx_start_o = w_tx_start;
  assign busy_o     = w_busy;
  assign done_o     = w_done;
  assign reg_addr_o = r_reg_addr;
  assign mem_addr_o = r_mem_addr;

endmodule
